// File: rtl/bcdr_drp_responder.sv
// DRP target model: register file plus a read-only PI-code status register, fixed-latency responses.
// Optional DRP_RESPONDER_STALL_EN adds 0..3 LFSR-driven extra cycles per transaction.
module bcdr_drp_responder #(
    parameter int          NUM_REGS = 32,
    parameter int          LATENCY  = 4,
    parameter logic [9:0]  PI_ADDR  = 10'h0A0
) (
    input  logic        drpClk,
    input  logic        resetN,
    input  logic [9:0]  drpAddr,
    input  logic [15:0] drpDin,
    input  logic        drpEn,
    input  logic        drpWe,
    output logic [15:0] drpDout,
    output logic        drpRdy,
    input  logic [6:0]  cdrPiCode,
    output logic        busy,
    output logic        protoErr,
    output logic [7:0]  errCount
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic [4:0]  r_cnt;
    logic [4:0]  w_lat;
    logic [9:0]  r_addr;
    logic        r_we;
    logic [15:0] r_din;
    logic [15:0] r_dout;
    logic        r_perr;
    logic [7:0]  r_errcnt;
    logic [15:0] r_regs [NUM_REGS];

    logic        w_acc, w_viol, w_commit;
    logic [9:0]  w_c_addr;
    logic        w_c_we;
    logic [15:0] w_c_din;
    logic        w_in_rf;
    logic [AW-1:0] w_idx;
    logic [15:0] w_rd_data;

    // Assert asynchronously, release two edges after resetN rises
    always_ff @(posedge drpClk or negedge resetN) begin
        if (!resetN) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef DRP_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    always_ff @(posedge drpClk or negedge w_rst_n) begin
        if (!w_rst_n) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[14:0], w_fb};
    end
    assign w_lat = 5'(LATENCY) + {3'b000, r_lfsr[1:0]};
`else
    assign w_lat = 5'(LATENCY);
`endif

    assign w_acc  = drpEn && (r_state != S_WAIT);
    assign w_viol = drpEn && (r_state == S_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (drpEn) w_next = (w_lat == 5'd1) ? S_RESP : S_WAIT;
                else       w_next = S_IDLE;
            end
            S_WAIT:  if (r_cnt == 5'd1) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Entering RESP from WAIT uses the latched request; otherwise it is a single-cycle request
    assign w_commit  = (w_next == S_RESP);
    assign w_c_addr  = (r_state == S_WAIT) ? r_addr : drpAddr;
    assign w_c_we    = (r_state == S_WAIT) ? r_we   : drpWe;
    assign w_c_din   = (r_state == S_WAIT) ? r_din  : drpDin;
    assign w_in_rf   = (w_c_addr < 10'(NUM_REGS));
    assign w_idx     = w_c_addr[AW-1:0];

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_in_rf)                   w_rd_data = r_regs[w_idx];
        else if (w_c_addr == PI_ADDR)  w_rd_data = {9'b0, cdrPiCode};
    end

    always_ff @(posedge drpClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_addr   <= 10'd0;
            r_we     <= 1'b0;
            r_din    <= 16'h0000;
            r_dout   <= 16'h0000;
            r_perr   <= 1'b0;
            r_errcnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_addr <= drpAddr;
                r_we   <= drpWe;
                r_din  <= drpDin;
                r_cnt  <= w_lat - 5'd1;
            end else if (r_state == S_WAIT) begin
                r_cnt  <= r_cnt - 5'd1;
            end
            if (w_commit && !w_c_we) r_dout <= w_rd_data;
            if (w_viol) begin
                r_perr <= 1'b1;
                if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge drpClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 16'h0000;
        end else if (w_commit && w_c_we && w_in_rf) begin
            r_regs[w_idx] <= w_c_din;
        end
    end

    assign drpDout  = r_dout;
    assign drpRdy   = (r_state == S_RESP);
    assign busy     = (r_state == S_WAIT);
    assign protoErr = r_perr;
    assign errCount = r_errcnt;

endmodule

// File: tb/tb_bcdr_drp_responder.sv
// Randomized scoreboard bench for bcdr_drp_responder; expected responses come from an array model of the register map.
module tb_bcdr_drp_responder;

    localparam int         L   = 4;
    localparam int         NR  = 32;
    localparam logic [9:0] PIA = 10'h0A0;

    logic        drpClk = 1'b0;
    logic        resetN;
    logic [9:0]  drpAddr;
    logic [15:0] drpDin;
    logic        drpEn;
    logic        drpWe;
    logic [15:0] drpDout;
    logic        drpRdy;
    logic [6:0]  cdrPiCode;
    logic        busy;
    logic        protoErr;
    logic [7:0]  errCount;

    bcdr_drp_responder #(.NUM_REGS(NR), .LATENCY(L), .PI_ADDR(PIA)) dut (
        .drpClk(drpClk), .resetN(resetN), .drpAddr(drpAddr), .drpDin(drpDin),
        .drpEn(drpEn), .drpWe(drpWe), .drpDout(drpDout), .drpRdy(drpRdy),
        .cdrPiCode(cdrPiCode), .busy(busy), .protoErr(protoErr), .errCount(errCount)
    );

    always #5 drpClk = ~drpClk;

    typedef struct {
        logic [15:0] dout;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] mem [NR];
    logic [15:0] last_dout;
    int          m_err;
    logic        m_perr;
    int          cyc;
    int          nid;
    int          checks;
    int          errors;

    always @(posedge drpClk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge drpClk) begin
        if (drpRdy === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy cyc=%0d actual=1 required=0", cyc);
            end else begin
                mon_e = q.pop_front();
                chk($sformatf("dout#%0d", mon_e.id), 32'(drpDout), 32'(mon_e.dout));
`ifdef DRP_RESPONDER_STALL_EN
                checks++;
                if (cyc < mon_e.cyc || cyc > mon_e.cyc + 3) begin
                    errors++;
                    $display("FAIL rdy_cycle#%0d actual=%0d required=%0d..%0d", mon_e.id, cyc, mon_e.cyc, mon_e.cyc + 3);
                end
`else
                chk($sformatf("rdy_cycle#%0d", mon_e.id), 32'(cyc), 32'(mon_e.cyc));
`endif
            end
        end
    end

    // vmode: 0 none, 1 random violations, 2 one violation two cycles after the request, 3 every busy cycle
    task automatic do_txn(input logic we, input logic [9:0] a, input logic [15:0] d, input int vmode);
        exp_t e;
        int   t;
        int   b;
        drpEn   = 1'b1;
        drpWe   = we;
        drpAddr = a;
        drpDin  = d;
        if (!we) begin
            if (a < NR)        last_dout = mem[a[4:0]];
            else if (a == PIA) last_dout = {9'b0, cdrPiCode};
            else               last_dout = 16'h0000;
        end else if (a < NR) begin
            mem[a[4:0]] = d;
        end
        e.dout = last_dout;
        e.cyc  = cyc + L;
        e.id   = nid++;
        q.push_back(e);
        @(posedge drpClk); #1;
        drpEn   = 1'b0;
        drpWe   = 1'($urandom_range(0, 1));
        drpAddr = 10'($urandom);
        drpDin  = 16'($urandom);
        t = 0;
        b = 0;
        while (drpRdy !== 1'b1 && t < 40) begin
            if (busy === 1'b1) begin
                if (vmode == 3 || (vmode == 2 && b == 1) || (vmode == 1 && $urandom_range(0, 3) == 0)) begin
                    drpEn   = 1'b1;
                    drpWe   = 1'($urandom_range(0, 1));
                    drpAddr = 10'($urandom_range(0, NR - 1));
                    drpDin  = 16'($urandom);
                    m_err   = (m_err < 255) ? m_err + 1 : 255;
                    m_perr  = 1'b1;
                end
                b++;
            end
            @(posedge drpClk); #1;
            drpEn = 1'b0;
            t++;
        end
        if (t >= 40) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout#%0d actual=none required=drpRdy", e.id);
        end
`ifdef DRP_RESPONDER_STALL_EN
        checks++;
        if (b < L - 1 || b > L + 2) begin
            errors++;
            $display("FAIL busy_cycles#%0d actual=%0d required=%0d..%0d", e.id, b, L - 1, L + 2);
        end
`else
        chk($sformatf("busy_cycles#%0d", e.id), 32'(b), 32'(L - 1));
`endif
        chk($sformatf("protoErr#%0d", e.id), 32'(protoErr), 32'(m_perr));
        chk($sformatf("errCount#%0d", e.id), 32'(errCount), 32'(m_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = 16'h0000;
        last_dout = 16'h0000;
        m_err     = 0;
        m_perr    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"},     32'(drpDout),  32'h0);
        chk({tag, "_rdy"},      32'(drpRdy),   32'h0);
        chk({tag, "_busy"},     32'(busy),     32'h0);
        chk({tag, "_protoErr"}, 32'(protoErr), 32'h0);
        chk({tag, "_errCount"}, 32'(errCount), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a;
        int         sel;
        resetN    = 1'b0;
        drpEn     = 1'b0;
        drpWe     = 1'b0;
        drpAddr   = 10'd0;
        drpDin    = 16'h0;
        cdrPiCode = 7'h00;
        model_reset();
        repeat (3) @(posedge drpClk);
        #1;
        chk_reset_outputs("reset");
        resetN = 1'b1;
        repeat (3) @(posedge drpClk);
        #1;

        // Directed cases
        do_txn(1'b0, 10'd5, 16'h0, 0);
        do_txn(1'b1, 10'd3, 16'hBEEF, 0);
        do_txn(1'b0, 10'd3, 16'h0, 0);
        cdrPiCode = 7'h55;
        do_txn(1'b0, PIA, 16'h0, 0);
        do_txn(1'b1, PIA, 16'hFFFF, 0);
        do_txn(1'b0, PIA, 16'h0, 0);
        do_txn(1'b0, 10'h3FF, 16'h0, 0);
        do_txn(1'b1, 10'd40, 16'h1234, 0);
        do_txn(1'b0, 10'd40, 16'h0, 0);
        do_txn(1'b0, 10'd7, 16'h0, 2);
        for (int i = 0; i < 100; i++) do_txn(1'b0, 10'(i % NR), 16'h0, 3);

        // Randomized traffic with gaps and sporadic violations
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 3);
            if (sel < 2)       a = 10'($urandom_range(0, NR - 1));
            else if (sel == 2) a = PIA;
            else               a = 10'($urandom);
            cdrPiCode = 7'($urandom);
            do_txn(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge drpClk);
                #1;
            end
        end

        // Reset in the middle of a write to register 1
        drpEn   = 1'b1;
        drpWe   = 1'b1;
        drpAddr = 10'd1;
        drpDin  = 16'hA5A5;
        @(posedge drpClk); #1;
        drpEn = 1'b0;
        @(posedge drpClk); #1;
        resetN = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (L + 2) @(posedge drpClk);
        #1;
        resetN = 1'b1;
        model_reset();
        repeat (3) @(posedge drpClk);
        #1;
        chk_reset_outputs("release");
        do_txn(1'b0, 10'd1, 16'h0, 0);
        do_txn(1'b0, 10'd3, 16'h0, 0);

        repeat (10) @(posedge drpClk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
